// File: rtl/strobe_sequencer.sv
// Sequences a counter_with_strobe through a programmed list of terminal counts,
// gating upstream ticks into single-cycle enables and reloading on each strobe.
module strobe_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [AW:0]      cfg_len,
  input  logic             cfg_loop,
  input  logic             start,
  input  logic             stop,
  input  logic             tick_in,
  output logic             ctr_rst,
  output logic             ctr_enable,
  output logic [WIDTH-1:0] ctr_reset_value,
  input  logic             ctr_strobe,
  input  logic             ctr_ready,
  input  logic             ctr_valid,
  output logic             busy,
  output logic [AW-1:0]    step_idx,
  output logic             step_done,
  output logic             seq_done,
  output logic             tick_drop,
  output logic             cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]      ONE_L   = (AW+1)'(1);
  localparam logic [WIDTH-1:0] MIN_TC  = WIDTH'(2);

  state_t           state_q, state_d;
  logic             ctr_enable_q, ctr_enable_d;
  logic [WIDTH-1:0] rv_q, rv_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW:0]      len_q, len_d;
  logic             loop_q, loop_d;
  logic             pending_q, pending_d;
  logic             after_load_q, after_load_d;
  logic             stop_rst_q, stop_rst_d;
  logic             step_done_q, step_done_d;
  logic             seq_done_q, seq_done_d;
  logic             tick_drop_q, tick_drop_d;
  logic             cfg_err_q, cfg_err_d;
  logic             tbl_we;
  logic [WIDTH-1:0] tbl_q [DEPTH];

  logic          pend_eff, issue, last_step;
  logic [AW-1:0] next_idx;

  assign pend_eff  = pending_q | tick_in;
  assign issue     = (state_q == S_RUN) && !stop && pend_eff && ctr_ready
                     && !ctr_enable_q && !after_load_q;
  assign last_step = ({1'b0, idx_q} == (len_q - ONE_L));
  assign next_idx  = idx_q + AW'(1);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    ctr_enable_d = 1'b0;
    rv_d         = rv_q;
    idx_d        = idx_q;
    len_d        = len_q;
    loop_d       = loop_q;
    pending_d    = pending_q;
    after_load_d = 1'b0;
    stop_rst_d   = 1'b0;
    step_done_d  = 1'b0;
    seq_done_d   = 1'b0;
    tick_drop_d  = 1'b0;
    cfg_err_d    = 1'b0;
    tbl_we       = 1'b0;

    if (cfg_we) begin
      if (state_q == S_IDLE && cfg_data >= MIN_TC && {1'b0, cfg_addr} < DEPTH_C)
        tbl_we = 1'b1;
      else
        cfg_err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        pending_d = 1'b0;
        if (start && !stop) begin
          state_d = S_LOAD;
          len_d   = (cfg_len == '0 || cfg_len > DEPTH_C) ? DEPTH_C : cfg_len;
          loop_d  = cfg_loop;
          idx_d   = '0;
          rv_d    = tbl_q[0];
        end
      end
      S_LOAD: begin
        // LOAD already drives ctr_rst, so an abort here needs no extra pulse.
        if (stop) state_d = S_IDLE;
        else begin
          state_d      = S_RUN;
          after_load_d = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d    = S_IDLE;
          pending_d  = 1'b0;
          stop_rst_d = 1'b1;
        end else begin
          if (issue) begin
            ctr_enable_d = 1'b1;
            pending_d    = pending_q & tick_in;
          end else begin
            pending_d   = pend_eff;
            tick_drop_d = tick_in & pending_q;
          end
          if (ctr_strobe) begin
            step_done_d = 1'b1;
            if (!last_step) begin
              idx_d = next_idx;
              rv_d  = tbl_q[next_idx];
            end else if (loop_q) begin
              idx_d = '0;
              rv_d  = tbl_q[0];
            end else begin
              state_d      = S_IDLE;
              seq_done_d   = 1'b1;
              pending_d    = 1'b0;
              ctr_enable_d = 1'b0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ctr_enable_q <= 1'b0;
      rv_q         <= MIN_TC;
      idx_q        <= '0;
      len_q        <= DEPTH_C;
      loop_q       <= 1'b0;
      pending_q    <= 1'b0;
      after_load_q <= 1'b0;
      stop_rst_q   <= 1'b0;
      step_done_q  <= 1'b0;
      seq_done_q   <= 1'b0;
      tick_drop_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctr_enable_q <= ctr_enable_d;
      rv_q         <= rv_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      loop_q       <= loop_d;
      pending_q    <= pending_d;
      after_load_q <= after_load_d;
      stop_rst_q   <= stop_rst_d;
      step_done_q  <= step_done_d;
      seq_done_q   <= seq_done_d;
      tick_drop_q  <= tick_drop_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // NOTE: the table is deliberately not reset; programmed counts survive rst.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[cfg_addr] <= cfg_data;
  end

  assign ctr_rst         = rst | (state_q == S_LOAD) | stop_rst_q;
  assign ctr_enable      = ctr_enable_q;
  assign ctr_reset_value = rv_q;
  assign busy            = (state_q != S_IDLE);
  assign step_idx        = idx_q;
  assign step_done       = step_done_q;
  assign seq_done        = seq_done_q;
  assign tick_drop       = tick_drop_q;
  assign cfg_err         = cfg_err_q;

  strobe_implies_valid: assert property (@(posedge clk) disable iff (rst) ctr_strobe |-> ctr_valid);

endmodule

// File: tb/tb_strobe_sequencer.sv
// Directed bench for strobe_sequencer with a behavioural counter (LATENCY = 2)
// standing in for counter_with_strobe.
module tb_strobe_sequencer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [WIDTH-1:0] cfg_data = '0;
  logic [AW:0] cfg_len = '0;
  logic cfg_loop = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic tick_in = 1'b0;
  logic ctr_rst, ctr_enable, busy, step_done, seq_done, tick_drop, cfg_err;
  logic [WIDTH-1:0] ctr_reset_value;
  logic [AW-1:0] step_idx;
  logic ctr_strobe = 1'b0;
  logic ctr_valid = 1'b0;
  logic ctr_ready;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  strobe_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .cfg_loop(cfg_loop), .start(start), .stop(stop), .tick_in(tick_in),
    .ctr_rst(ctr_rst), .ctr_enable(ctr_enable), .ctr_reset_value(ctr_reset_value),
    .ctr_strobe(ctr_strobe), .ctr_ready(ctr_ready), .ctr_valid(ctr_valid),
    .busy(busy), .step_idx(step_idx), .step_done(step_done), .seq_done(seq_done),
    .tick_drop(tick_drop), .cfg_err(cfg_err)
  );

  // Behavioural counter: strobes the cycle after the enable that reaches the terminal count.
  logic [WIDTH-1:0] m_cnt = '0;
  int m_busy = 0;
  assign ctr_ready = (m_busy == 0);
  always @(posedge clk) begin
    if (ctr_rst) begin
      m_cnt <= '0; ctr_strobe <= 1'b0; ctr_valid <= 1'b0; m_busy <= 0;
    end else begin
      ctr_strobe <= 1'b0; ctr_valid <= 1'b0;
      if (m_busy != 0) m_busy <= m_busy - 1;
      if (ctr_enable) begin
        m_busy <= LATENCY - 1;
        if (m_cnt + 4'd1 == ctr_reset_value) begin
          m_cnt <= '0; ctr_strobe <= 1'b1; ctr_valid <= 1'b1;
        end else m_cnt <= m_cnt + 4'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Enable must never repeat on consecutive cycles nor follow/overlap ctr_rst.
  logic prev_en = 1'b0, prev_rst = 1'b0;
  always @(negedge clk) begin
    if (!rst && ctr_enable) check("enable_spacing", {prev_en, prev_rst, ctr_rst}, 32'd0);
    prev_en = ctr_enable;
    prev_rst = ctr_rst;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic exp_err);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step(1);
    cfg_we = 1'b0;
    check("cfg_err", cfg_err, exp_err);
  endtask

  task automatic do_start(input logic [AW:0] len, input logic lp);
    cfg_len = len; cfg_loop = lp; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // One tick, observed over 4 cycles: enable at n+1, strobe at n+2, step results at n+3.
  task automatic do_tick(output logic en, output logic drop, output logic stb,
                         output logic sd, output logic sq,
                         output logic [AW-1:0] idx, output logic [WIDTH-1:0] rv);
    tick_in = 1'b1;
    step(1);
    tick_in = 1'b0;
    en = ctr_enable; drop = tick_drop;
    step(1);
    stb = ctr_strobe;
    step(1);
    sd = step_done; sq = seq_done; idx = step_idx; rv = ctr_reset_value;
    step(1);
  endtask

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             exp_err;
  } cfg_vec_t;

  cfg_vec_t vecs [6];
  logic en, drop, stb, sd, sq;
  logic [AW-1:0] idx;
  logic [WIDTH-1:0] rv;
  logic [WIDTH-1:0] loop_vals [3];
  int exp_idx;
  int n_en, n_drop;
  logic [12:0] en_seen, drop_seen;

  initial begin
    vecs[0] = '{addr: 2'd0, data: 4'd3,  exp_err: 1'b0};
    vecs[1] = '{addr: 2'd1, data: 4'd3,  exp_err: 1'b0};
    vecs[2] = '{addr: 2'd2, data: 4'd4,  exp_err: 1'b0};
    vecs[3] = '{addr: 2'd3, data: 4'd15, exp_err: 1'b0};
    vecs[4] = '{addr: 2'd0, data: 4'd1,  exp_err: 1'b1};
    vecs[5] = '{addr: 2'd1, data: 4'd0,  exp_err: 1'b1};
    loop_vals[0] = 4'd2; loop_vals[1] = 4'd3; loop_vals[2] = 4'd4;

    // Reset state
    step(2);
    check("rst_ctr_rst", ctr_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_enable", ctr_enable, 0);
    check("rst_rv", ctr_reset_value, 2);
    check("rst_idx", step_idx, 0);
    check("rst_pulses", {step_done, seq_done, tick_drop, cfg_err}, 0);
    rst = 1'b0;
    step(1);
    check("ctr_rst_low", ctr_rst, 0);

    for (int i = 0; i < 6; i++) cfg_write(vecs[i].addr, vecs[i].data, vecs[i].exp_err);

    // Single entry, no loop; rejected write of 1 must have left table[0] = 3
    do_start(3'd1, 1'b0);
    check("load_busy", busy, 1);
    check("load_ctr_rst", ctr_rst, 1);
    check("load_rv", ctr_reset_value, 3);
    step(2);
    for (int k = 1; k <= 3; k++) begin
      do_tick(en, drop, stb, sd, sq, idx, rv);
      check("single_en", en, 1);
      check("single_stb", stb, k == 3);
      check("single_step_done", sd, k == 3);
      check("single_seq_done", sq, k == 3);
    end
    check("single_busy_end", busy, 0);
    check("single_rv_hold", ctr_reset_value, 3);
    do_tick(en, drop, stb, sd, sq, idx, rv);
    check("idle_tick_en", en, 0);
    check("idle_tick_drop", drop, 0);

    // Loop wrap over {2,3,4}
    cfg_write(2'd0, 4'd2, 1'b0);
    do_start(3'd3, 1'b1);
    check("loop_load_rv", ctr_reset_value, 2);
    step(2);
    exp_idx = 0;
    for (int k = 1; k <= 17; k++) begin
      do_tick(en, drop, stb, sd, sq, idx, rv);
      check("loop_en", en, 1);
      check("loop_stb", stb, k == 2 || k == 5 || k == 9 || k == 11 || k == 14);
      if (stb) begin
        exp_idx = (exp_idx + 1) % 3;
        check("loop_step_done", sd, 1);
        check("loop_idx", idx, exp_idx);
        check("loop_rv", rv, loop_vals[exp_idx]);
      end
    end
    check("loop_busy", busy, 1);

    // Stop on the strobe cycle of tick 18
    tick_in = 1'b1;
    step(1);
    tick_in = 1'b0;
    check("stop_en", ctr_enable, 1);
    step(1);
    check("stop_strobe", ctr_strobe, 1);
    check("stop_pre_rst", ctr_rst, 0);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("stop_no_step_done", step_done, 0);
    check("stop_idle", busy, 0);
    check("stop_ctr_rst", ctr_rst, 1);
    check("stop_enable", ctr_enable, 0);
    step(1);
    check("stop_ctr_rst_once", ctr_rst, 0);

    // Restart from entry 0, then back-pressure with three back-to-back ticks
    do_start(3'd3, 1'b1);
    check("restart_idx", step_idx, 0);
    check("restart_rv", ctr_reset_value, 2);
    step(2);
    tick_in = 1'b1;
    n_en = 0; n_drop = 0; en_seen = '0; drop_seen = '0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (i == 3) tick_in = 1'b0;
      en_seen[i] = ctr_enable;
      drop_seen[i] = tick_drop;
      n_en += int'(ctr_enable);
      n_drop += int'(tick_drop);
    end
    check("bp_enable_count", n_en, 2);
    check("bp_drop_count", n_drop, 1);
    check("bp_enable_cycles", en_seen, 13'b0_0000_0001_0010);
    check("bp_drop_cycle", drop_seen, 13'b0_0000_0000_1000);
    check("bp_idx", step_idx, 1);

    // Reset mid-run with pending set
    tick_in = 1'b1;
    step(1);
    check("rr_first_en", ctr_enable, 1);
    step(1);
    tick_in = 1'b0;
    check("rr_pending_no_en", ctr_enable, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rr_busy", busy, 0);
    check("rr_idx", step_idx, 0);
    check("rr_rv", ctr_reset_value, 2);
    check("rr_pulses", {ctr_enable, step_done, seq_done, tick_drop, cfg_err}, 0);
    for (int i = 0; i < 2; i++) begin
      step(1);
      check("rr_no_enable", ctr_enable, 0);
    end

    // Write while busy is rejected; entry 1 keeps 3
    do_start(3'd2, 1'b0);
    step(1);
    cfg_write(2'd1, 4'd9, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("busy_no_stale_enable", ctr_enable, 0);
    end
    do_tick(en, drop, stb, sd, sq, idx, rv);
    do_tick(en, drop, stb, sd, sq, idx, rv);
    check("busy_wr_step", sd, 1);
    check("busy_wr_rv", rv, 3);
    check("busy_wr_idx", idx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
